// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: shared state encoding, LUT entry layout and special entry values
package cam_cfg_pkg;
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_PWR_WAIT = 4'd1;
  localparam state_t ST_FETCH    = 4'd2;
  localparam state_t ST_DECODE   = 4'd3;
  localparam state_t ST_WR       = 4'd4;
  localparam state_t ST_WR_WAIT  = 4'd5;
  localparam state_t ST_RD       = 4'd6;
  localparam state_t ST_RD_WAIT  = 4'd7;
  localparam state_t ST_GAP      = 4'd8;
  localparam state_t ST_DELAY    = 4'd9;
  localparam state_t ST_DONE     = 4'd10;
  localparam state_t ST_FAIL     = 4'd11;
  localparam logic [7:0] DELAY_DEV = 8'h00;
  localparam int DATA_LSB = 0;
  function automatic int dev_msb(int reg_w, int data_w);
    return reg_w + data_w + 7;
  endfunction
  function automatic int reg_lsb(int data_w);
    return data_w;
  endfunction
endpackage

// File: rtl/cam_cfg_sequencer_timer.sv
// cfg_cycle_timer: loadable down-counter; done is high once the loaded cycle count has elapsed
module cfg_cycle_timer #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_CNT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] cycles,
  output logic         done
);
  logic [W-1:0] cnt;
  // loading N-1 makes the waiting state last exactly N cycles (at least one)
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= RST_CNT;
    else if (load) cnt <= (cycles == '0) ? '0 : cycles - 1'b1;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign done = cnt == '0;
endmodule

// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer: walks a sensor register LUT and issues each entry as an I2C/SCCB write
module cam_cfg_sequencer import cam_cfg_pkg::*; #(
  parameter int LUT_DEPTH = 303,
  parameter int INDEX_W = 10,
  parameter int REG_ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LUT_LAT = 0,
  parameter logic [19:0] PWRUP_CYC = 20'd1000000,
  parameter logic [15:0] GAP_CYC = 16'd100,
  parameter logic [15:0] TICK_CYC = 16'd50000,
  parameter bit VERIFY = 1'b0,
  parameter int MAX_RETRY = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [INDEX_W-1:0]           lut_index,
  input  logic [8+REG_ADDR_W+DATA_W-1:0] lut_data,
  output logic                         i2c_req,
  output logic                         i2c_rnw,
  output logic [7:0]                   i2c_dev,
  output logic [REG_ADDR_W-1:0]        i2c_addr,
  output logic [DATA_W-1:0]            i2c_wdata,
  input  logic [DATA_W-1:0]            i2c_rdata,
  input  logic                         i2c_ack,
  input  logic                         i2c_err,
  output logic                         busy,
  output logic                         cfg_done,
  output logic                         cfg_err,
  output logic [INDEX_W-1:0]           err_index,
  output logic [INDEX_W-1:0]           entry_cnt
);
  localparam int EW = 8 + REG_ADDR_W + DATA_W;
  localparam int DEV_MSB = dev_msb(REG_ADDR_W, DATA_W);
  localparam int REG_L = reg_lsb(DATA_W);
  localparam logic [INDEX_W-1:0] IDX_END = INDEX_W'(LUT_DEPTH);
  localparam logic [3:0] LAT = 4'(LUT_LAT);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [31:0] PWR = 32'(PWRUP_CYC);
  localparam logic [31:0] PWR_RST = (PWR == 32'd0) ? 32'd0 : PWR - 32'd1;
  localparam logic [31:0] GAP = 32'(GAP_CYC);
  state_t state;
  logic [EW-1:0] entry;
  logic [3:0] lat_cnt, retry_cnt;
  logic [31:0] delay, tmr_val;
  logic gap_retry, tmr_load, tmr_done, sentinel, is_delay, fail, can_retry, wait_st, adv, retry_inc;
  assign i2c_dev = entry[DEV_MSB -: 8];
  assign i2c_addr = entry[REG_L +: REG_ADDR_W];
  assign i2c_wdata = entry[DATA_LSB +: DATA_W];
  assign delay = 32'(entry[15:0]) * 32'(TICK_CYC);
  assign sentinel = (&entry) || lut_index == IDX_END;
  assign is_delay = i2c_dev == DELAY_DEV;
  assign wait_st = state == ST_WR_WAIT || state == ST_RD_WAIT;
  // err wins over a simultaneous ack; a readback mismatch is also a failure
  assign fail = i2c_err || (state == ST_RD_WAIT && i2c_ack && i2c_rdata != i2c_wdata);
  assign can_retry = retry_cnt < RETRY_MAX;
  assign retry_inc = wait_st && fail && can_retry;
  assign adv = (state == ST_DECODE && !sentinel && is_delay && delay == 32'd0) ||
               (state == ST_DELAY && tmr_done) || (state == ST_GAP && tmr_done && !gap_retry);
  assign tmr_load = state == ST_DECODE || (state == ST_IDLE && start) || (wait_st && (i2c_ack || i2c_err));
  assign tmr_val = state == ST_DECODE ? delay : state == ST_IDLE ? PWR : GAP;
  cfg_cycle_timer #(.W(32), .RST_CNT(PWR_RST)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(tmr_load), .cycles(tmr_val), .done(tmr_done)
  );
  always_ff @(posedge clk) begin
    if (!rst_n || (state == ST_IDLE && start)) begin
      lut_index <= '0;
      entry_cnt <= '0;
      retry_cnt <= '0;
    end else if (adv) begin
      lut_index <= lut_index + 1'b1;
      entry_cnt <= entry_cnt + 1'b1;
      retry_cnt <= '0;
    end else if (retry_inc) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_PWR_WAIT;
      entry <= '0;
      lat_cnt <= '0;
      gap_retry <= 1'b0;
      i2c_req <= 1'b0;
      i2c_rnw <= 1'b0;
      busy <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
      err_index <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_PWR_WAIT;
          busy <= 1'b1;
          cfg_done <= 1'b0;
          cfg_err <= 1'b0;
          err_index <= '0;
        end
        ST_PWR_WAIT: begin
          busy <= 1'b1;
          if (tmr_done) state <= ST_FETCH;
        end
        ST_FETCH: if (lat_cnt == LAT) begin
          entry <= lut_data;
          lat_cnt <= '0;
          state <= ST_DECODE;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
        ST_DECODE: if (sentinel) begin
          state <= ST_DONE;
          cfg_done <= 1'b1;
          busy <= 1'b0;
        end else begin
          state <= !is_delay ? ST_WR : (delay == 32'd0) ? ST_FETCH : ST_DELAY;
        end
        ST_DELAY: if (tmr_done) state <= ST_FETCH;
        ST_WR, ST_RD: begin
          i2c_req <= 1'b1;
          i2c_rnw <= state == ST_RD;
          state <= state == ST_RD ? ST_RD_WAIT : ST_WR_WAIT;
        end
        ST_WR_WAIT, ST_RD_WAIT: if (fail || i2c_ack) begin
          i2c_req <= 1'b0;
          gap_retry <= fail;
          if (fail && !can_retry) begin
            state <= ST_FAIL;
            cfg_err <= 1'b1;
            err_index <= lut_index;
            busy <= 1'b0;
          end else begin
            state <= (!fail && VERIFY && state == ST_WR_WAIT) ? ST_RD : ST_GAP;
          end
        end
        ST_GAP: if (tmr_done) state <= gap_retry ? ST_WR : ST_FETCH;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// tb_cam_cfg_sequencer: randomized LUT passes against an I2C responder, scoreboarded transaction stream
module tb_cam_cfg_sequencer;
  localparam int DEPTH = 5, IW = 4, G = 8, T = 10, MR = 3;
  typedef struct { logic rnw; logic [31:0] e; int gmin; int gmax; } txn_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [IW-1:0] lut_index, err_index, entry_cnt;
  logic [31:0] lut_data;
  logic i2c_req, i2c_rnw, i2c_ack = 1'b0, i2c_err = 1'b0, busy, cfg_done, cfg_err;
  logic [7:0] i2c_dev, i2c_wdata, i2c_rdata = 8'h00;
  logic [15:0] i2c_addr;
  logic [31:0] lut [DEPTH];
  int tests = 0, fails = 0;
  int err_idx = -1, err_n = 0, err_left = 0, bad_idx = -1;
  bit both = 1'b0;
  txn_t q[$];
  txn_t t;
  bit exp_done, exp_err;
  int exp_eidx, exp_cnt, low = 0;
  logic prev = 1'b0;
  int li;

  always #5 clk = ~clk;
  assign li = int'(lut_index);
  assign lut_data = (li < DEPTH) ? lut[li] : '1;

  cam_cfg_sequencer #(
    .LUT_DEPTH(DEPTH), .INDEX_W(IW), .REG_ADDR_W(16), .DATA_W(8), .LUT_LAT(0),
    .PWRUP_CYC(20'd20), .GAP_CYC(16'(G)), .TICK_CYC(16'(T)), .VERIFY(1'b1), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lut_index(lut_index), .lut_data(lut_data),
    .i2c_req(i2c_req), .i2c_rnw(i2c_rnw), .i2c_dev(i2c_dev), .i2c_addr(i2c_addr),
    .i2c_wdata(i2c_wdata), .i2c_rdata(i2c_rdata), .i2c_ack(i2c_ack), .i2c_err(i2c_err),
    .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_index(err_index), .entry_cnt(entry_cnt)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(string name, int v, int lo, int hi);
    tests++;
    if (v < lo || v > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  // I2C responder: random latency, optional error injection and corrupted readback
  always begin
    @(negedge clk);
    if (rst_n && i2c_req) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (rst_n && i2c_req) begin
        if (!i2c_rnw && li == err_idx && err_left > 0) begin
          err_left--;
          i2c_err = 1'b1;
          i2c_ack = both;
        end else begin
          i2c_ack = 1'b1;
          i2c_rdata = lut[li][7:0] ^ ((li == bad_idx) ? 8'h01 : 8'h00);
        end
        @(negedge clk);
        i2c_ack = 1'b0;
        i2c_err = 1'b0;
      end
    end
  end

  // monitor: every new request is popped off the scoreboard and checked
  always @(negedge clk) begin
    if (!rst_n) begin
      prev = 1'b0;
      low = 0;
    end else begin
      if (i2c_req && !prev) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: got request at index %0d, expected none", lut_index);
        end else begin
          t = q.pop_front();
          chk("req_fields", {i2c_rnw, i2c_dev, i2c_addr, i2c_rnw ? 8'h00 : i2c_wdata},
              {t.rnw, t.e[31:8], t.rnw ? 8'h00 : t.e[7:0]});
          if (t.gmin >= 0) chk_range("req_gap", low, t.gmin, t.gmax);
        end
        low = 0;
      end
      if (!i2c_req) low++;
      prev = i2c_req;
    end
  end

  // reference: expected transaction list and pass outcome from LUT contents and injected faults
  task automatic model();
    int gmin = -1, gmax = -1;
    bit stop = 1'b0;
    exp_err = 1'b0;
    exp_eidx = 0;
    exp_cnt = 0;
    for (int i = 0; i < DEPTH && !stop; i++) begin
      logic [31:0] e = lut[i];
      if (e == '1) begin
        stop = 1'b1;
      end else if (e[31:24] == 8'h00) begin
        if (gmin >= 0) begin
          gmin += int'(e[15:0]) * T;
          gmax += int'(e[15:0]) * T + 3;
        end
        exp_cnt++;
      end else begin
        bit ok = 1'b0;
        for (int a = 0; a <= MR && !ok; a++) begin
          q.push_back('{1'b0, e, gmin, gmax});
          gmin = G;
          gmax = G + 4;
          if (i == err_idx && a < err_n) continue;
          q.push_back('{1'b1, e, 1, 2});
          ok = (i != bad_idx);
        end
        if (ok) exp_cnt++;
        else begin
          exp_err = 1'b1;
          exp_eidx = i;
          stop = 1'b1;
        end
      end
    end
    exp_done = !exp_err;
  endtask

  function automatic logic [31:0] rand_entry(bit allow_dly);
    logic [31:0] e = {8'($urandom_range(1, 254)), 16'($urandom), 8'($urandom)};
    if (allow_dly && $urandom_range(0, 4) == 0) e = {8'h00, 16'h0000, 8'($urandom_range(0, 3))};
    return e;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_pass(string n);
    int c = 0;
    while (!busy && c < 50) begin @(negedge clk); c++; end
    while (busy && c < 6000) begin @(negedge clk); c++; end
    chk({n, "_end"}, 64'(busy), 64'd0);
    chk({n, "_done"}, 64'(cfg_done), 64'(exp_done));
    chk({n, "_err"}, 64'(cfg_err), 64'(exp_err));
    chk({n, "_eidx"}, 64'(err_index), 64'(exp_eidx));
    chk({n, "_cnt"}, 64'(entry_cnt), 64'(exp_cnt));
    chk({n, "_pending"}, 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic setup(int ei, int en, int bi, bit b);
    err_idx = ei;
    err_n = en;
    err_left = en;
    bad_idx = bi;
    both = b;
  endtask

  task automatic run(string n, int ei, int en, int bi, bit b);
    setup(ei, en, bi, b);
    model();
    pulse_start();
    wait_pass(n);
  endtask

  function automatic logic [63:0] outs();
    return 64'({i2c_req, i2c_rnw, i2c_dev, i2c_addr, i2c_wdata, busy, cfg_done, cfg_err,
                err_index, entry_cnt, lut_index});
  endfunction

  initial begin
    int c;
    for (int i = 0; i < DEPTH; i++) lut[i] = rand_entry(1'b0);
    lut[0] = 32'h78310311;
    setup(-1, 0, -1, 1'b0);
    model();
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;
    wait_pass("basic");
    lut[2] = '1;
    run("sentinel", -1, 0, -1, 1'b0);
    lut[2] = 32'h00000003;
    run("delay", -1, 0, -1, 1'b0);
    lut[2] = rand_entry(1'b0);
    run("bad_readback", -1, 0, 1, 1'b0);
    run("err_retry", 0, 1, -1, 1'b0);
    run("ack_err_same", 3, 1, -1, 1'b1);
    run("err_exhaust", 2, 4, -1, 1'b0);
    setup(-1, 0, -1, 1'b0);
    model();
    pulse_start();
    repeat (40) @(negedge clk);
    pulse_start();
    wait_pass("start_busy");
    model();
    pulse_start();
    c = 0;
    while (!i2c_req && c < 500) begin @(negedge clk); c++; end
    chk("mid_req_seen", 64'(i2c_req), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", outs(), 64'd0);
    q.delete();
    model();
    rst_n = 1'b1;
    wait_pass("after_reset");
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < DEPTH; i++) lut[i] = rand_entry(1'b1);
      if ($urandom_range(0, 3) == 0) lut[$urandom_range(1, DEPTH - 1)] = '1;
      run("random", ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DEPTH - 1)) : -1,
          int'($urandom_range(0, 4)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : -1,
          1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
